// File: rtl/booth_seq_ctrl.sv
// ---------------------------------------------------------------------------
// booth_seq_ctrl
//
// Sequential unsigned 16x16 -> 32 radix-2 shift-add multiplier controller.
// All addition goes through an external 16-bit adder (combinational, same
// cycle). The only adder inside this block is the 4-bit step counter.
//
// Ports
//   clk_i         rising-edge clock
//   rst_i         asynchronous active-high reset
//   in_valid_i    operand pair offered on in1_i/in2_i
//   in_ready_o    operand pair accepted this cycle (high only in IDLE)
//   in1_i[15:0]   unsigned multiplicand
//   in2_i[15:0]   unsigned multiplier
//   out_valid_o   product_o holds a completed result (DONE state)
//   out_ready_i   consumer takes product_o this cycle
//   product_o     unsigned in1*in2, valid only while out_valid_o=1
//   busy_o        multiply in progress (RUN state)
//   add_in1_o     external adder operand 1 (partial high word A)
//   add_in2_o     external adder operand 2 (M when Q[0]=1, else 0)
//   add_sum_i     external adder result, carry-out in bit 16
// ---------------------------------------------------------------------------
module booth_seq_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [15:0] in1_i,
  input  logic [15:0] in2_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] product_o,
  output logic        busy_o,
  output logic [15:0] add_in1_o,
  output logic [15:0] add_in2_o,
  input  logic [16:0] add_sum_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] m_q, m_d;
  logic [15:0] a_q, a_d;
  logic [15:0] q_q, q_d;
  logic [3:0]  cnt_q, cnt_d;

  // State and datapath registers; reset clears everything so the
  // outputs read as zero while and after reset is applied.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      m_q     <= '0;
      a_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      a_q     <= a_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. Latency is fixed: 16 RUN steps regardless of the
  // operand values, so there is no early exit on a zero multiplier.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid_i)     state_d = RUN;
      RUN:  if (cnt_q == 4'd15) state_d = DONE;
      DONE: if (out_ready_i)    state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  // Datapath next-state. Each RUN step adds M (or 0) to A, then shifts
  // {carry, sum, Q} right by one: the adder's carry-out becomes A[15] and
  // the sum LSB drops into Q[15] while the consumed multiplier bit leaves.
  always_comb begin
    m_d   = m_q;
    a_d   = a_q;
    q_d   = q_q;
    cnt_d = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          m_d   = in1_i;
          q_d   = in2_i;
          a_d   = '0;
          cnt_d = '0;
        end
      end
      RUN: begin
        a_d   = add_sum_i[16:1];
        q_d   = {add_sum_i[0], q_q[15:1]};
        cnt_d = cnt_q + 4'd1;
      end
      default: ;
    endcase
  end

  // Outputs decoded from the current state and registers only.
  always_comb begin
    in_ready_o  = (state_q == IDLE);
    busy_o      = (state_q == RUN);
    out_valid_o = (state_q == DONE);
    product_o   = {a_q, q_q};
    add_in1_o   = a_q;
    add_in2_o   = q_q[0] ? m_q : 16'h0000;
  end

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_booth_seq_ctrl
//
// Bench for booth_seq_ctrl. Provides the external 17-bit adder, drives
// directed operand pairs plus a short random run, and checks results
// through a scoreboard queue popped by an independent monitor process.
// ---------------------------------------------------------------------------
module tb_booth_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in1;
  logic [15:0] in2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] product;
  logic        busy;
  logic [15:0] add_in1;
  logic [15:0] add_in2;
  logic [16:0] add_sum;

  int cmp_cnt = 0;
  int err_cnt = 0;
  logic [31:0] exp_q[$];

  booth_seq_ctrl dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in1_i       (in1),
    .in2_i       (in2),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .product_o   (product),
    .busy_o      (busy),
    .add_in1_o   (add_in1),
    .add_in2_o   (add_in2),
    .add_sum_i   (add_sum)
  );

  // External adder model.
  assign add_sum = {1'b0, add_in1} + {1'b0, add_in2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops on handoff, checks stability while stalled, and flags
  // any result presented with nothing outstanding (e.g. an aborted op).
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else if (out_ready) begin
        check("product", product, exp_q.pop_front());
      end else begin
        check("product_stall_stable", product, exp_q[0]);
      end
    end
  end

  // Called #1 after the accepting edge. Measures latency and BUSY length,
  // optionally verifies ADD_IN2 stays zero, stalls, then hands off.
  task automatic wait_done(input int stall, input bit chk_zero);
    int n;
    int busy_n;
    bit nz;
    n = 0;
    busy_n = 0;
    nz = 1'b0;
    while (!out_valid && n < 40) begin
      if (busy) busy_n++;
      if (busy && add_in2 != 16'h0) nz = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", 32'(n), 32'd16);
    check("busy_cycles", 32'(busy_n), 32'd16);
    if (chk_zero) check("add_in2_zero", 32'(nz), 32'd0);
    if (!out_valid) return;
    repeat (stall) begin
      @(posedge clk);
      #1;
    end
    if (stall > 0) check("valid_held_in_stall", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_after_handoff", 32'(in_ready), 32'd1);
    check("out_valid_after_handoff", 32'(out_valid), 32'd0);
  endtask

  task automatic issue(input logic [15:0] x, input logic [15:0] y,
                       input logic [31:0] exp, input int stall,
                       input bit chk_zero);
    int k;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("in_ready_wait", 32'(in_ready), 32'd1);
    in1 = x;
    in2 = y;
    in_valid = 1'b1;
    out_ready = (stall == 0);
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in1 = 16'($urandom);
    in2 = 16'($urandom);
    wait_done(stall, chk_zero);
  endtask

  initial begin
    logic [15:0] rx, ry;
    rst = 1'b1;
    in_valid = 1'b0;
    in1 = '0;
    in2 = '0;
    out_ready = 1'b0;
    #3;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_product", product, 32'd0);
    check("rst_add_in1", 32'(add_in1), 32'd0);
    check("rst_add_in2", 32'(add_in2), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors with hand-computed products.
    issue(16'd3, 16'd5, 32'h0000_000F, 0, 1'b0);
    issue(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 0, 1'b0);
    issue(16'h1234, 16'h0000, 32'h0000_0000, 0, 1'b1);
    issue(16'h00FF, 16'h0100, 32'h0000_FF00, 5, 1'b0);

    // Abort mid-RUN at CNT=7: nothing is pushed, so any later OUT_VALID
    // for this pair is caught by the monitor.
    @(negedge clk);
    in1 = 16'h5555;
    in2 = 16'h3333;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_product", product, 32'd0);
    check("abort_add_in1", 32'(add_in1), 32'd0);
    check("abort_add_in2", 32'(add_in2), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    issue(16'h8000, 16'h0002, 32'h0001_0000, 0, 1'b0);

    // IN_VALID held high with changing operands through RUN and DONE.
    @(negedge clk);
    in1 = 16'd3;
    in2 = 16'd7;
    in_valid = 1'b1;
    out_ready = 1'b1;
    exp_q.push_back(32'd21);
    @(posedge clk);
    #1;
    for (int k = 0; k < 60 && !in_ready; k++) begin
      in1 = 16'($urandom);
      in2 = 16'($urandom);
      @(posedge clk);
      #1;
    end
    check("held_valid_return_idle", 32'(in_ready), 32'd1);
    in1 = 16'h0011;
    in2 = 16'h0022;
    exp_q.push_back(32'h0000_0242);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_done(0, 1'b0);

    // Short random run against a 32-bit reference product.
    for (int i = 0; i < 300; i++) begin
      rx = 16'($urandom);
      ry = 16'($urandom);
      if (i % 50 == 0) ry = 16'hFFFF;
      issue(rx, ry, 32'(rx) * 32'(ry), int'($urandom_range(0, 3)), 1'b0);
    end

    repeat (4) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  // Absolute time bound so the bench always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
